ldq_violation_detect: RTL and testbench

//  Consumes the LDQ CAM match vector produced by a store-address search and finds the

---
 rtl/ldq_violation_detect_if.sv | 42 ++++
 rtl/ldq_violation_detect.sv | 111 +++++++++++
 tb/tb_ldq_violation_detect.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ldq_violation_detect_if.sv
// Bundle between the store-search/LDQ side and the violation detector.
// The viol_count_o member exists only when LDQ_VIOL_STATS_EN is defined.
interface ldq_violation_detect_if #(
   parameter int DEPTH = 16,
   parameter int INDEX = 4
);
   logic             flush_i;
   logic             search_valid_i;
   logic [INDEX-1:0] search_idx_i;
   logic [DEPTH-1:0] match_vect_i;
   logic [DEPTH-1:0] ldq_executed_i;
   logic [INDEX-1:0] ldq_head_i;
   logic [INDEX-1:0] ldq_tail_i;
   logic             viol_valid_o;
   logic [INDEX-1:0] viol_idx_o;
   logic             viol_ready_i;
`ifdef LDQ_VIOL_STATS_EN
   logic [15:0]      viol_count_o;

   modport master (
      output flush_i, search_valid_i, search_idx_i, match_vect_i,
             ldq_executed_i, ldq_head_i, ldq_tail_i, viol_ready_i,
      input  viol_valid_o, viol_idx_o, viol_count_o
   );
   modport slave (
      input  flush_i, search_valid_i, search_idx_i, match_vect_i,
             ldq_executed_i, ldq_head_i, ldq_tail_i, viol_ready_i,
      output viol_valid_o, viol_idx_o, viol_count_o
   );
`else
   modport master (
      output flush_i, search_valid_i, search_idx_i, match_vect_i,
             ldq_executed_i, ldq_head_i, ldq_tail_i, viol_ready_i,
      input  viol_valid_o, viol_idx_o
   );
   modport slave (
      input  flush_i, search_valid_i, search_idx_i, match_vect_i,
             ldq_executed_i, ldq_head_i, ldq_tail_i, viol_ready_i,
      output viol_valid_o, viol_idx_o
   );
`endif
endinterface

// File: rtl/ldq_violation_detect.sv
// Memory-ordering violation detector. Stage 1 masks the LDQ CAM match vector
// down to executed loads younger than the store; stage 2 picks the oldest of
// them with a rotate-priority search; an output register holds the report
// until the recovery unit accepts it, keeping the older of competing reports.
// Optional statistics counter: define LDQ_VIOL_STATS_EN.
module ldq_violation_detect #(
   parameter int DEPTH = 16,
   parameter int INDEX = 4
) (
   input logic                  clk,
   input logic                  reset_n,
   ldq_violation_detect_if.slave bus
);

   // circular range [search_idx, tail); empty when both are equal
   logic [DEPTH-1:0] yng;
   for (genvar g = 0; g < DEPTH; g++) begin : g_yng
      localparam logic [INDEX-1:0] POS = INDEX'(g);
      assign yng[g] = (bus.search_idx_i <= bus.ldq_tail_i) ?
                      (POS >= bus.search_idx_i && POS < bus.ldq_tail_i) :
                      (POS >= bus.search_idx_i || POS < bus.ldq_tail_i);
   end

   logic             s1_valid;
   logic [DEPTH-1:0] s1_cand;
   logic [INDEX-1:0] s1_idx;
   logic [INDEX-1:0] s1_head;

   // stage 1: capture the masked candidate vector and search context
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_cand  <= '0;
         s1_idx   <= '0;
         s1_head  <= '0;
      end else if (bus.flush_i) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= bus.search_valid_i;
         if (bus.search_valid_i) begin
            s1_cand <= bus.match_vect_i & bus.ldq_executed_i & yng;
            s1_idx  <= bus.search_idx_i;
            s1_head <= bus.ldq_head_i;
         end
      end
   end

   // stage 2: rotate so the store's first younger load sits at bit 0
   logic [2*DEPTH-1:0] dbl;
   logic [DEPTH-1:0]   rot;
   assign dbl = {s1_cand, s1_cand} >> s1_idx;
   assign rot = dbl[DEPTH-1:0];

   logic             any;
   logic [INDEX-1:0] k;
   // lowest set bit of the rotated vector is the oldest younger load
   always_comb begin
      any = 1'b0;
      k   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (rot[i]) begin
            any = 1'b1;
            k   = INDEX'(i);
         end
      end
   end

   logic             viol_valid;
   logic [INDEX-1:0] viol_idx;
   logic             s2_hit;
   logic [INDEX-1:0] new_idx;
   logic [INDEX-1:0] new_age;
   logic [INDEX-1:0] held_age;
   logic             take;

   assign s2_hit   = s1_valid & any;
   assign new_idx  = s1_idx + k;
   assign new_age  = new_idx - s1_head;
   assign held_age = viol_idx - s1_head;
   // a strictly older result displaces a held report; ties keep the held one
   assign take     = s2_hit & (~viol_valid | bus.viol_ready_i | (new_age < held_age));

   // output register with valid/ready handshake
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         viol_valid <= 1'b0;
         viol_idx   <= '0;
      end else if (bus.flush_i) begin
         viol_valid <= 1'b0;
      end else if (take) begin
         viol_valid <= 1'b1;
         viol_idx   <= new_idx;
      end else if (viol_valid && bus.viol_ready_i) begin
         viol_valid <= 1'b0;
      end
   end

   assign bus.viol_valid_o = viol_valid;
   assign bus.viol_idx_o   = viol_idx;

`ifdef LDQ_VIOL_STATS_EN
   logic [15:0] viol_count;
   // counts every stage-2 violation, kept or dropped; only reset clears it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                             viol_count <= '0;
      else if (s2_hit && viol_count != 16'hFFFF) viol_count <= viol_count + 16'd1;
   end
   assign bus.viol_count_o = viol_count;
`endif

endmodule

// File: tb/tb_ldq_violation_detect.sv
// Directed bench for ldq_violation_detect: basic hit, wrap, filtering,
// stall/replace, handshake-with-new-result, flush, async reset, stats.
module tb_ldq_violation_detect;
   localparam int DEPTH = 16;
   localparam int INDEX = 4;

   logic clk = 1'b0;
   logic reset_n;
   int   total = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   ldq_violation_detect_if #(.DEPTH(DEPTH), .INDEX(INDEX)) bus ();

   ldq_violation_detect #(.DEPTH(DEPTH), .INDEX(INDEX)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic srch(input logic [3:0] s, input logic [3:0] t, input logic [3:0] h,
                       input logic [15:0] m, input logic [15:0] e);
      bus.search_valid_i = 1'b1;
      bus.search_idx_i   = s;
      bus.ldq_tail_i     = t;
      bus.ldq_head_i     = h;
      bus.match_vect_i   = m;
      bus.ldq_executed_i = e;
   endtask

   task automatic idle();
      bus.search_valid_i = 1'b0;
   endtask

   initial begin
      reset_n            = 1'b0;
      bus.flush_i        = 1'b0;
      bus.viol_ready_i   = 1'b0;
      bus.search_valid_i = 1'b0;
      bus.search_idx_i   = '0;
      bus.match_vect_i   = '0;
      bus.ldq_executed_i = '0;
      bus.ldq_head_i     = '0;
      bus.ldq_tail_i     = '0;
      #2;
      chk("rst_valid", 16'(bus.viol_valid_o), 16'd0);
      chk("rst_idx",   16'(bus.viol_idx_o),   16'd0);
`ifdef LDQ_VIOL_STATS_EN
      chk("rst_count", bus.viol_count_o, 16'd0);
`endif
      reset_n = 1'b1;
      tick();

      // basic hit: candidates 4,5 -> 4, two-cycle latency
      srch(4'd3, 4'd8, 4'd0, 16'h0030, 16'hFFFF); tick(); idle();
      chk("basic_n1_valid", 16'(bus.viol_valid_o), 16'd0);
      tick();
      chk("basic_valid", 16'(bus.viol_valid_o), 16'd1);
      chk("basic_idx",   16'(bus.viol_idx_o),   16'd4);
      bus.viol_ready_i = 1'b1; tick(); bus.viol_ready_i = 1'b0;
      chk("basic_ack", 16'(bus.viol_valid_o), 16'd0);

      // wrap: bit 14 preferred over bit 1
      srch(4'd14, 4'd4, 4'd12, 16'h4002, 16'hFFFF); tick(); idle(); tick();
      chk("wrap_valid", 16'(bus.viol_valid_o), 16'd1);
      chk("wrap_idx",   16'(bus.viol_idx_o),   16'd14);
      bus.viol_ready_i = 1'b1; tick(); bus.viol_ready_i = 1'b0;
      chk("wrap_ack", 16'(bus.viol_valid_o), 16'd0);
      srch(4'd14, 4'd4, 4'd12, 16'h0002, 16'hFFFF); tick(); idle(); tick();
      chk("wrap1_valid", 16'(bus.viol_valid_o), 16'd1);
      chk("wrap1_idx",   16'(bus.viol_idx_o),   16'd1);
      bus.viol_ready_i = 1'b1; tick(); bus.viol_ready_i = 1'b0;
      chk("wrap1_ack", 16'(bus.viol_valid_o), 16'd0);

      // filtered: not executed
      srch(4'd3, 4'd8, 4'd0, 16'h0010, 16'h0000); tick(); idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("filt_exec", 16'(bus.viol_valid_o), 16'd0);
      end
      // filtered: outside [3,8)
      srch(4'd3, 4'd8, 4'd0, 16'h0200, 16'hFFFF); tick(); idle(); tick(); tick();
      chk("filt_range", 16'(bus.viol_valid_o), 16'd0);
      // filtered: empty range
      srch(4'd5, 4'd5, 4'd0, 16'h0020, 16'hFFFF); tick(); idle(); tick(); tick();
      chk("filt_empty", 16'(bus.viol_valid_o), 16'd0);

      // stall/replace: held 6, older 2 replaces, younger 9 dropped
      srch(4'd6, 4'd15, 4'd0, 16'h0040, 16'hFFFF); tick();
      srch(4'd2, 4'd15, 4'd0, 16'h0004, 16'hFFFF); tick();
      chk("stall_idx6", 16'(bus.viol_idx_o), 16'd6);
      srch(4'd9, 4'd15, 4'd0, 16'h0200, 16'hFFFF); tick(); idle();
      chk("stall_idx2", 16'(bus.viol_idx_o), 16'd2);
      tick();
      chk("stall_keep_valid", 16'(bus.viol_valid_o), 16'd1);
      chk("stall_keep_idx",   16'(bus.viol_idx_o),   16'd2);
      tick();
      chk("stall_hold_idx", 16'(bus.viol_idx_o), 16'd2);
      bus.viol_ready_i = 1'b1; tick(); bus.viol_ready_i = 1'b0;
      chk("stall_ack", 16'(bus.viol_valid_o), 16'd0);

      // handshake and younger result in the same cycle: new result loads
      srch(4'd6, 4'd15, 4'd0, 16'h0040, 16'hFFFF); tick();
      srch(4'd9, 4'd15, 4'd0, 16'h0200, 16'hFFFF); tick(); idle();
      chk("hs_held6", 16'(bus.viol_idx_o), 16'd6);
      bus.viol_ready_i = 1'b1; tick();
      chk("hs_valid", 16'(bus.viol_valid_o), 16'd1);
      chk("hs_idx9",  16'(bus.viol_idx_o),   16'd9);
      tick(); bus.viol_ready_i = 1'b0;
      chk("hs_drop", 16'(bus.viol_valid_o), 16'd0);

      // flush one cycle after the search: report never rises
      srch(4'd3, 4'd8, 4'd0, 16'h0030, 16'hFFFF); tick(); idle();
      bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
      chk("flush_n2", 16'(bus.viol_valid_o), 16'd0);
      tick();
      chk("flush_n3", 16'(bus.viol_valid_o), 16'd0);
      // flush clears a held report despite no handshake
      srch(4'd3, 4'd8, 4'd0, 16'h0030, 16'hFFFF); tick(); idle(); tick();
      chk("flush_held_pre", 16'(bus.viol_valid_o), 16'd1);
      bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
      chk("flush_held", 16'(bus.viol_valid_o), 16'd0);

      // asynchronous reset between edges
      srch(4'd3, 4'd8, 4'd0, 16'h0030, 16'hFFFF); tick(); idle(); tick();
      chk("areset_pre", 16'(bus.viol_valid_o), 16'd1);
      #3 reset_n = 1'b0;
      #1;
      chk("areset_valid", 16'(bus.viol_valid_o), 16'd0);
      chk("areset_idx",   16'(bus.viol_idx_o),   16'd0);
`ifdef LDQ_VIOL_STATS_EN
      chk("areset_count", bus.viol_count_o, 16'd0);
`endif
      reset_n = 1'b1;
      tick(); tick();
      chk("areset_post", 16'(bus.viol_valid_o), 16'd0);

      // three violations back-to-back, no ready: oldest (4) held
      srch(4'd3, 4'd8, 4'd0, 16'h0010, 16'hFFFF); tick();
      srch(4'd3, 4'd8, 4'd0, 16'h0020, 16'hFFFF); tick();
      srch(4'd3, 4'd8, 4'd0, 16'h0040, 16'hFFFF); tick(); idle();
      tick(); tick();
      chk("burst_valid", 16'(bus.viol_valid_o), 16'd1);
      chk("burst_idx",   16'(bus.viol_idx_o),   16'd4);
`ifdef LDQ_VIOL_STATS_EN
      chk("burst_count", bus.viol_count_o, 16'd3);
      bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
      chk("count_flush_keep", bus.viol_count_o, 16'd3);
`endif

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
